// File: rtl/clause_scan_controller.sv
// Sweeps the clause table one row per cycle and stops on the first row whose
// active literals are all falsified. Memory data returns one cycle after each read.
module clause_scan_controller #(
  parameter int NUM_ROWS     = 64,
  parameter int COLS_PER_ROW = 4,
  parameter int LIT_WIDTH    = 6,
  localparam int ROW_W       = $clog2(NUM_ROWS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic [ROW_W:0]                    num_rows,
  output logic                              busy,
  output logic                              done,
  output logic                              conflict_found,
  output logic [ROW_W-1:0]                  conflict_row,
  output logic                              aborted,
  output logic                              mem_rd_en,
  output logic [ROW_W-1:0]                  mem_addr,
  input  logic [COLS_PER_ROW*LIT_WIDTH-1:0] mem_static_row,
  input  logic [COLS_PER_ROW-1:0]           mem_dynamic_row
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic [ROW_W:0] MAX_ROWS = (ROW_W + 1)'(NUM_ROWS);
  localparam logic [ROW_W:0] ONE_ROW  = (ROW_W + 1)'(1);

  logic [1:0]       state_q, state_d;
  logic [ROW_W:0]   issue_ptr_q, issue_ptr_d;
  logic [ROW_W:0]   num_rows_q, num_rows_d;
  logic             ret_valid_q, ret_valid_d;
  logic [ROW_W-1:0] ret_tag_q, ret_tag_d;
  logic             conflict_found_q, conflict_found_d;
  logic [ROW_W-1:0] conflict_row_q, conflict_row_d;
  logic             aborted_q, aborted_d;

  logic [ROW_W:0]   num_rows_clamped;
  logic             any_active;
  logic             all_falsified;
  logic             row_conflict;
  logic             last_return;

  assign num_rows_clamped = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;

  // Empty slots are ignored; a row with no active slot can never conflict.
  always_comb begin
    any_active    = 1'b0;
    all_falsified = 1'b1;
    for (int i = 0; i < COLS_PER_ROW; i++) begin
      if (mem_static_row[i*LIT_WIDTH +: LIT_WIDTH] != '0) begin
        any_active = 1'b1;
        if (!mem_dynamic_row[i]) begin
          all_falsified = 1'b0;
        end
      end
    end
  end

  assign row_conflict = ret_valid_q && any_active && all_falsified;
  // Reads are back-to-back, so the last return is the one seen once every read is out.
  assign last_return  = ret_valid_q && (issue_ptr_q == num_rows_q);

  assign mem_rd_en = (state_q == SCAN) && (issue_ptr_q < num_rows_q) && !row_conflict && !abort;
  assign mem_addr  = issue_ptr_q[ROW_W-1:0];

  always_comb begin
    state_d          = state_q;
    issue_ptr_d      = issue_ptr_q;
    num_rows_d       = num_rows_q;
    ret_valid_d      = mem_rd_en;
    ret_tag_d        = mem_addr;
    conflict_found_d = conflict_found_q;
    conflict_row_d   = conflict_row_q;
    aborted_d        = aborted_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          conflict_found_d = 1'b0;
          conflict_row_d   = '0;
          aborted_d        = 1'b0;
          issue_ptr_d      = '0;
          num_rows_d       = num_rows_clamped;
          state_d          = (num_rows_clamped == '0) ? FINISH : SCAN;
        end
      end
      SCAN: begin
        if (mem_rd_en) begin
          issue_ptr_d = issue_ptr_q + ONE_ROW;
        end
        // A conflict returning in the abort cycle takes priority over the abort.
        if (row_conflict) begin
          conflict_found_d = 1'b1;
          conflict_row_d   = ret_tag_q;
          state_d          = FINISH;
        end else if (abort) begin
          aborted_d = 1'b1;
          state_d   = FINISH;
        end else if (last_return) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      issue_ptr_q      <= '0;
      num_rows_q       <= '0;
      ret_valid_q      <= 1'b0;
      ret_tag_q        <= '0;
      conflict_found_q <= 1'b0;
      conflict_row_q   <= '0;
      aborted_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      issue_ptr_q      <= issue_ptr_d;
      num_rows_q       <= num_rows_d;
      ret_valid_q      <= ret_valid_d;
      ret_tag_q        <= ret_tag_d;
      conflict_found_q <= conflict_found_d;
      conflict_row_q   <= conflict_row_d;
      aborted_q        <= aborted_d;
    end
  end

  assign busy           = (state_q == SCAN);
  assign done           = (state_q == FINISH);
  assign conflict_found = conflict_found_q;
  assign conflict_row   = conflict_row_q;
  assign aborted        = aborted_q;

endmodule

// File: tb/tb_clause_scan_controller.sv
// Scoreboard bench for clause_scan_controller: directed scans push expected reads and
// results into queues, and a negedge monitor pops and compares them as the DUT emits them.
module tb_clause_scan_controller;

  localparam int NUM_ROWS     = 16;
  localparam int COLS_PER_ROW = 4;
  localparam int LIT_WIDTH    = 6;
  localparam int ROW_W        = $clog2(NUM_ROWS);
  localparam int SW           = COLS_PER_ROW * LIT_WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [ROW_W:0]   num_rows;
  logic             busy;
  logic             done;
  logic             conflict_found;
  logic [ROW_W-1:0] conflict_row;
  logic             aborted;
  logic             mem_rd_en;
  logic [ROW_W-1:0] mem_addr;
  logic [SW-1:0]    mem_static_row = '0;
  logic [COLS_PER_ROW-1:0] mem_dynamic_row = '0;

  logic [SW-1:0]           st_mem [NUM_ROWS];
  logic [COLS_PER_ROW-1:0] dy_mem [NUM_ROWS];

  typedef struct { int cyc; int addr; } rd_t;
  typedef struct { int cyc; bit cf; int row; bit ab; } res_t;
  rd_t  rd_q[$];
  res_t res_q[$];

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  bit  mon_en = 1'b0;

  clause_scan_controller #(
    .NUM_ROWS(NUM_ROWS), .COLS_PER_ROW(COLS_PER_ROW), .LIT_WIDTH(LIT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_rows(num_rows),
    .busy(busy), .done(done), .conflict_found(conflict_found),
    .conflict_row(conflict_row), .aborted(aborted), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_static_row(mem_static_row),
    .mem_dynamic_row(mem_dynamic_row)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Clause memory model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_static_row  <= st_mem[mem_addr];
      mem_dynamic_row <= dy_mem[mem_addr];
    end
  end

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every read strobe and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_rd_en) begin
        if (rd_q.size() == 0) begin
          check_output("unexpected_read_addr", int'(mem_addr), -1);
        end else begin
          rd_t e;
          e = rd_q.pop_front();
          check_output("read_cycle", cyc, e.cyc);
          check_output("read_addr", int'(mem_addr), e.addr);
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          check_output("unexpected_done", int'(done), 0);
        end else begin
          res_t r;
          r = res_q.pop_front();
          check_output("done_cycle", cyc, r.cyc);
          check_output("conflict_found", int'(conflict_found), int'(r.cf));
          check_output("conflict_row", int'(conflict_row), r.row);
          check_output("aborted", int'(aborted), int'(r.ab));
          check_output("busy_in_done", int'(busy), 0);
        end
      end
    end
  end

  task automatic fill_clean();
    for (int r = 0; r < NUM_ROWS; r++) begin
      st_mem[r] = {6'd4, 6'd3, 6'd2, 6'd1};
      dy_mem[r] = 4'b0000;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_busy"}, int'(busy), 0);
    check_output({tag, "_done"}, int'(done), 0);
    check_output({tag, "_conflict_found"}, int'(conflict_found), 0);
    check_output({tag, "_conflict_row"}, int'(conflict_row), 0);
    check_output({tag, "_aborted"}, int'(aborted), 0);
    check_output({tag, "_mem_rd_en"}, int'(mem_rd_en), 0);
  endtask

  // One scan: start at cycle T, expected reads at T+1.., done at T+done_off (0 = none).
  task automatic apply_stimulus(input int n, input int exp_reads, input int done_off,
                                input bit exp_cf, input int exp_row, input bit exp_ab,
                                input int abort_off, input int spur_off, input int rst_off);
    int t0;
    int limit;
    res_t r;
    @(posedge clk);
    #1;
    start    = 1'b1;
    num_rows = (ROW_W + 1)'(n);
    t0       = cyc;
    for (int i = 0; i < exp_reads; i++) begin
      rd_t e;
      e.cyc  = t0 + 1 + i;
      e.addr = i;
      rd_q.push_back(e);
    end
    if (done_off > 0) begin
      r.cyc = t0 + done_off;
      r.cf  = exp_cf;
      r.row = exp_row;
      r.ab  = exp_ab;
      res_q.push_back(r);
    end
    limit = (done_off > 0) ? done_off + 2 : rst_off + 1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk);
      #1;
      start = (k == spur_off);
      if (k == spur_off) num_rows = (ROW_W + 1)'(3);
      abort = (k == abort_off);
      rst   = (k == rst_off);
      if (rst_off > 0 && k == rst_off + 1) check_all_zero("after_reset");
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    check_output("reads_outstanding", rd_q.size(), 0);
    check_output("results_outstanding", res_q.size(), 0);
    rd_q.delete();
    res_q.delete();
    if (done_off > 0) begin
      check_output("hold_conflict_found", int'(conflict_found), int'(exp_cf));
      check_output("hold_conflict_row", int'(conflict_row), exp_row);
      check_output("hold_aborted", int'(aborted), int'(exp_ab));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    num_rows = '0;
    fill_clean();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset");
    check_output("reset_mem_addr", int'(mem_addr), 0);
    mon_en = 1'b1;

    // Clean sweep of 8 rows.
    apply_stimulus(8, 8, 10, 1'b0, 0, 1'b0, 0, 0, 0);

    // Row 5 literals {3,7,0,0} with both active slots falsified.
    fill_clean();
    st_mem[5] = {6'd0, 6'd0, 6'd7, 6'd3};
    dy_mem[5] = 4'b0011;
    apply_stimulus(8, 6, 8, 1'b1, 5, 1'b0, 0, 0, 0);

    // Empty row with all dynamic bits set, and a partially falsified row: no conflict.
    fill_clean();
    st_mem[2] = '0;
    dy_mem[2] = 4'b1111;
    dy_mem[4] = 4'b1110;
    apply_stimulus(8, 8, 10, 1'b0, 0, 1'b0, 0, 0, 0);

    // Abort at T+4 with no conflicts.
    fill_clean();
    apply_stimulus(10, 3, 5, 1'b0, 0, 1'b1, 4, 0, 0);

    // Abort at T+4 coinciding with the row-2 conflict: conflict wins.
    st_mem[2] = {6'd0, 6'd0, 6'd0, 6'd5};
    dy_mem[2] = 4'b0001;
    apply_stimulus(10, 3, 5, 1'b1, 2, 1'b0, 4, 0, 0);

    // Zero rows: straight to done.
    fill_clean();
    apply_stimulus(0, 0, 1, 1'b0, 0, 1'b0, 0, 0, 0);

    // Oversized request clamps to the table size.
    apply_stimulus(20, 16, 18, 1'b0, 0, 1'b0, 0, 0, 0);

    // Conflict on the very last row of a full table.
    dy_mem[15] = 4'b1111;
    apply_stimulus(16, 16, 18, 1'b1, 15, 1'b0, 0, 0, 0);

    // Conflict on row 0 of a one-row scan.
    fill_clean();
    dy_mem[0] = 4'b1111;
    apply_stimulus(1, 1, 3, 1'b1, 0, 1'b0, 0, 0, 0);

    // Start pulsed during SCAN with a different row count is ignored.
    fill_clean();
    apply_stimulus(8, 8, 10, 1'b0, 0, 1'b0, 0, 3, 0);

    // Reset at T+3 mid-scan, then a clean scan started at T+5.
    apply_stimulus(10, 3, 0, 1'b0, 0, 1'b0, 0, 0, 3);
    apply_stimulus(4, 4, 6, 1'b0, 0, 1'b0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clause_scan_controller.md
# clause_scan_controller

Sequencer that sweeps a clause table row by row and reports the first conflicting clause. On `start` it issues one read per cycle to the external clause memory, covering static literal fields and dynamic falsified bits. It evaluates each returned row against the conflict rule and stops issuing reads on the first conflict. It sits between the solver control FSM and the clause storage, and replaces ad-hoc per-row polling.

## Interface
- `NUM_ROWS`, 64, capacity of the clause table; `ROW_W` = $clog2(NUM_ROWS)
- `COLS_PER_ROW`, 4, literal slots per clause row
- `LIT_WIDTH`, 6, bits per literal field; value 0 means empty slot

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a scan; sampled only in IDLE
- `abort`  in  1  terminate the scan in progress; sampled only in SCAN
- `num_rows`  in  ROW_W+1  rows to scan; latched at start; values above NUM_ROWS are clamped to NUM_ROWS
- `busy`  out  1  high in SCAN
- `done`  out  1  single-cycle completion pulse
- `conflict_found`  out  1  scan ended on a conflicting row
- `conflict_row`  out  ROW_W  index of the first conflicting row
- `aborted`  out  1  scan ended by `abort`
- `mem_rd_en`  out  1  clause memory read strobe
- `mem_addr`  out  ROW_W  clause memory read address
- `mem_static_row`  in  COLS_PER_ROW*LIT_WIDTH  literal fields; valid the cycle after the read
- `mem_dynamic_row`  in  COLS_PER_ROW  per-slot falsified bits; valid the cycle after the read

## Operation
- States: IDLE, SCAN, FINISH.
  - IDLE -> SCAN on `start`. If the latched `num_rows` is 0, go IDLE -> FINISH instead.
  - SCAN -> FINISH on conflict, on `abort`, or when the last row has been returned.
  - FINISH -> IDLE unconditionally.
- Start handling:
  - Accepting `start` clears `conflict_found`, `conflict_row` and `aborted`, and zeroes `issue_ptr`.
  - `start` outside IDLE is ignored.
- Read issue:
  - `mem_rd_en` = SCAN && `issue_ptr` < latched `num_rows` && !`row_conflict` && !`abort`.
  - `mem_addr` = `issue_ptr`. `issue_ptr` increments on each read.
- Return pipeline:
  - A one-cycle valid flag and row tag follow each read.
  - The returned row is evaluated combinationally in the return cycle.
- Conflict rule:
  - Slot i is active if its literal field is nonzero.
  - `row_conflict` = return valid && every active slot has its dynamic bit set && at least one slot is active.
  - A row with all slots empty never conflicts.
- On conflict: register `conflict_found`=1 and `conflict_row`=tag, then enter FINISH.
- On `abort` without a conflict in the same cycle: register `aborted`=1, then enter FINISH. Data still in flight is discarded.
- Conflict and `abort` in the same cycle: conflict wins and `aborted` stays 0.
- `done` = 1 exactly in FINISH.
- Result outputs hold their values until the next accepted `start`.

## Timing
- Reset values: state IDLE; all outputs 0; `issue_ptr` 0; return-valid flag 0.
- Reset mid-scan: IDLE on the next edge. The in-flight return is dropped and `done` is not pulsed.
- Let `start` be sampled at cycle T, with N = clamped `num_rows`.
- No conflict:
  - Reads at T+1..T+N on addresses 0..N-1.
  - Returns at T+2..T+N+1.
  - `done` at T+N+2 with `conflict_found`=0.
- First conflict on row r:
  - Reads at T+1..T+r+1; `mem_rd_en` is low at T+r+2, so exactly r+1 reads are issued.
  - `done` at T+r+3 with `conflict_row`=r.
- N=0: no reads; `done` at T+1.
- `abort` sampled at cycle A in SCAN: no read at A; `done` at A+1 with `aborted`=1.
- `busy` is low in the `done` cycle. A new `start` is accepted from the cycle after `done`.
- Throughput: one row per cycle; no bubbles within a scan.

## Test plan
- NUM_ROWS=16, num_rows=8, no row conflicting -> addresses 0..7 on consecutive cycles, `done` at T+10, `conflict_found`=0.
- Row 5 = literals {3,7,0,0}, dynamic 4'b0011; other rows have a clear dynamic bit -> 6 reads, `done` at T+8, `conflict_found`=1, `conflict_row`=5.
- Row 2 all literals 0, dynamic 4'b1111 -> no conflict on row 2; scan continues to completion.
- `abort` at T+4 with num_rows=10 -> no read at T+4, `done` at T+5, `aborted`=1, `conflict_found`=0. Repeat with row 2 conflicting so the conflict lands in the abort cycle -> `conflict_found`=1, `aborted`=0.
- num_rows=0 -> `done` at T+1, `mem_rd_en` never high. num_rows=20 -> clamped to 16 reads.
- `rst` at T+3 mid-scan -> all outputs 0 at T+4, no `done`. A `start` at T+5 then runs a clean scan. `start` pulsed during SCAN -> ignored.
